csr_access_arbiter: RTL and testbench

Single-port CSR RAM access controller that sits between the SPI byte interface and the CSR storage of the core. It decodes the SPI command/data byte stream into CSR reads and writes, and shares the single RAM port with an on-chip hardware requester (PWM/GPIO update engines). A registered FSM grants one access per slot and returns read data with a valid strobe to the winner.

---
 rtl/csr_pkg.sv | 28 ++
 rtl/csr_access_arbiter_if.sv | 43 ++++
 rtl/csr_spi_decoder.sv | 72 +++++++
 rtl/csr_access_arbiter.sv | 140 ++++++++++++++
 tb/tb_csr_access_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared types and default widths for the CSR access arbiter slice.
package csr_pkg;

  localparam int unsigned CSR_ADDR_WIDTH = 6;
  localparam int unsigned CSR_DATA_WIDTH = 8;
  localparam int unsigned CSR_DEPTH      = 32;

  // Command byte is {op, addr}
  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_RD  = 2'b01,
    OP_WR  = 2'b10,
    OP_ILL = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    FE_CMD,
    FE_DATA,
    FE_PEND
  } fe_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACC,
    ARB_RD
  } arb_state_e;

endpackage

// File: rtl/csr_access_arbiter_if.sv
// SPI byte stream, hardware requester and RAM port signals of the CSR access arbiter.
interface csr_access_arbiter_if
  import csr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CSR_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CSR_DATA_WIDTH
);

  logic                  spi_valid;
  logic [DATA_WIDTH-1:0] spi_data;
  logic                  spi_ready;
  logic [DATA_WIDTH-1:0] spi_rdata;
  logic                  spi_rvalid;

  logic                  hw_req;
  logic                  hw_we;
  logic [ADDR_WIDTH-1:0] hw_addr;
  logic [DATA_WIDTH-1:0] hw_wdata;
  logic                  hw_gnt;
  logic [DATA_WIDTH-1:0] hw_rdata;
  logic                  hw_rvalid;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  err;

  modport slave (
    input  spi_valid, spi_data, hw_req, hw_we, hw_addr, hw_wdata, ram_rdata,
    output spi_ready, spi_rdata, spi_rvalid, hw_gnt, hw_rdata, hw_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata, err
  );

  modport master (
    output spi_valid, spi_data, hw_req, hw_we, hw_addr, hw_wdata, ram_rdata,
    input  spi_ready, spi_rdata, spi_rvalid, hw_gnt, hw_rdata, hw_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata, err
  );

endinterface

// File: rtl/csr_spi_decoder.sv
// SPI command/data byte decoder: turns the byte stream into one pending CSR access.
module csr_spi_decoder
  import csr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CSR_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CSR_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_valid_i,
  input  logic [DATA_WIDTH-1:0] spi_data_i,
  input  logic                  done_i,
  output logic                  spi_ready_c_o,
  output logic                  pend_o,
  output logic                  pend_we_o,
  output logic [ADDR_WIDTH-1:0] pend_addr_o,
  output logic [DATA_WIDTH-1:0] pend_wdata_o,
  output logic                  ill_op_c_o
);

  fe_state_e             fe_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept_c;
  csr_op_e               op_c;

  assign op_c          = csr_op_e'(spi_data_i[DATA_WIDTH-1 -: 2]);
  // Ready is forced low while reset is asserted so no byte is consumed then
  assign spi_ready_c_o = !rst && (fe_q != FE_PEND);
  assign accept_c      = spi_valid_i && spi_ready_c_o;
  assign ill_op_c_o    = accept_c && (fe_q == FE_CMD) && (op_c == OP_ILL);

  assign pend_o       = (fe_q == FE_PEND);
  assign pend_we_o    = we_q;
  assign pend_addr_o  = addr_q;
  assign pend_wdata_o = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fe_q    <= FE_CMD;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (fe_q)
        FE_CMD: begin
          if (accept_c && op_c == OP_RD) begin
            we_q   <= 1'b0;
            addr_q <= spi_data_i[ADDR_WIDTH-1:0];
            fe_q   <= FE_PEND;
          end else if (accept_c && op_c == OP_WR) begin
            we_q   <= 1'b1;
            addr_q <= spi_data_i[ADDR_WIDTH-1:0];
            fe_q   <= FE_DATA;
          end
        end
        FE_DATA: begin
          if (accept_c) begin
            wdata_q <= spi_data_i;
            fe_q    <= FE_PEND;
          end
        end
        FE_PEND: begin
          if (done_i) fe_q <= FE_CMD;
        end
        default: fe_q <= FE_CMD;
      endcase
    end
  end

endmodule

// File: rtl/csr_access_arbiter.sv
// Shares the single CSR RAM port between the SPI decoder and the hardware requester.
// CSR_ARB_ROUND_ROBIN_EN selects alternating priority; otherwise SPI wins ties.
module csr_access_arbiter
  import csr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CSR_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CSR_DATA_WIDTH,
  parameter int unsigned DEPTH      = CSR_DEPTH
) (
  input logic                  clk,
  input logic                  rst,
  csr_access_arbiter_if.slave  bus
);

  logic                  spi_pend, pend_we, ill_op_c, spi_ready_c, done_c;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [DATA_WIDTH-1:0] pend_wdata;

  csr_spi_decoder #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_spi_decoder (
    .clk          (clk),
    .rst          (rst),
    .spi_valid_i  (bus.spi_valid),
    .spi_data_i   (bus.spi_data),
    .done_i       (done_c),
    .spi_ready_c_o(spi_ready_c),
    .pend_o       (spi_pend),
    .pend_we_o    (pend_we),
    .pend_addr_o  (pend_addr),
    .pend_wdata_o (pend_wdata),
    .ill_op_c_o   (ill_op_c)
  );

  arb_state_e            arb_q;
  logic                  win_hw_q, acc_we_q, acc_bad_q;
  logic                  ram_en_q, ram_we_q, hw_gnt_q, err_q;
  logic                  spi_rvalid_q, hw_rvalid_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q, spi_rdata_q, hw_rdata_q;
`ifdef CSR_ARB_ROUND_ROBIN_EN
  logic                  hw_prio_q;
`endif

  logic                  grant_any_c, grant_hw_c, sel_we_c, sel_bad_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c, rd_data_c;

  // Winner selection and the access it would issue
  always_comb begin
    grant_any_c = spi_pend || bus.hw_req;
`ifdef CSR_ARB_ROUND_ROBIN_EN
    grant_hw_c  = bus.hw_req && (!spi_pend || hw_prio_q);
`else
    grant_hw_c  = bus.hw_req && !spi_pend;
`endif
    sel_we_c    = grant_hw_c ? bus.hw_we    : pend_we;
    sel_addr_c  = grant_hw_c ? bus.hw_addr  : pend_addr;
    sel_wdata_c = grant_hw_c ? bus.hw_wdata : pend_wdata;
    sel_bad_c   = 32'(sel_addr_c) >= 32'(DEPTH);
  end

  assign rd_data_c = acc_bad_q ? '0 : bus.ram_rdata;
  // SPI write completes in ACC, SPI read completes in RD
  assign done_c    = !win_hw_q && (((arb_q == ARB_ACC) && acc_we_q) || (arb_q == ARB_RD));

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_q        <= ARB_IDLE;
      win_hw_q     <= 1'b0;
      acc_we_q     <= 1'b0;
      acc_bad_q    <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      hw_gnt_q     <= 1'b0;
      err_q        <= 1'b0;
      spi_rvalid_q <= 1'b0;
      hw_rvalid_q  <= 1'b0;
      spi_rdata_q  <= '0;
      hw_rdata_q   <= '0;
`ifdef CSR_ARB_ROUND_ROBIN_EN
      hw_prio_q    <= 1'b0;
`endif
    end else begin
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      hw_gnt_q     <= 1'b0;
      spi_rvalid_q <= 1'b0;
      hw_rvalid_q  <= 1'b0;
      err_q        <= ill_op_c;
      case (arb_q)
        ARB_IDLE: begin
          if (grant_any_c) begin
            arb_q       <= ARB_ACC;
            win_hw_q    <= grant_hw_c;
            acc_we_q    <= sel_we_c;
            acc_bad_q   <= sel_bad_c;
            ram_en_q    <= !sel_bad_c;
            ram_we_q    <= sel_we_c && !sel_bad_c;
            ram_addr_q  <= sel_addr_c;
            ram_wdata_q <= sel_wdata_c;
            hw_gnt_q    <= grant_hw_c;
            if (sel_bad_c) err_q <= 1'b1;
`ifdef CSR_ARB_ROUND_ROBIN_EN
            hw_prio_q   <= !grant_hw_c;
`endif
          end
        end
        ARB_ACC: arb_q <= acc_we_q ? ARB_IDLE : ARB_RD;
        ARB_RD: begin
          arb_q <= ARB_IDLE;
          if (win_hw_q) begin
            hw_rdata_q  <= rd_data_c;
            hw_rvalid_q <= 1'b1;
          end else begin
            spi_rdata_q  <= rd_data_c;
            spi_rvalid_q <= 1'b1;
          end
        end
        default: arb_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.spi_ready  = spi_ready_c;
  assign bus.spi_rdata  = spi_rdata_q;
  assign bus.spi_rvalid = spi_rvalid_q;
  assign bus.hw_gnt     = hw_gnt_q;
  assign bus.hw_rdata   = hw_rdata_q;
  assign bus.hw_rvalid  = hw_rvalid_q;
  assign bus.ram_en     = ram_en_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Randomized bench for csr_access_arbiter against a transaction-level CSR memory model.
module tb_csr_access_arbiter;

  localparam int unsigned DEPTH = 32;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  csr_access_arbiter_if bus ();
  csr_access_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  // RAM stand-in, one cycle read latency
  logic [7:0] init_val [64];
  logic [7:0] mem [64];
  logic       ram_load;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val[i];
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  // Output monitor: event counters only
  int cyc, err_cnt, we_cnt, en_cnt, gnt_cnt, spi_rv_cnt, hw_rv_cnt;
  int bad_en_cnt, we_long_cnt, order_n, spi_acc_cyc, spi_rv_cyc;
  logic [7:0] last_spi_rdata, last_hw_rdata;
  bit order_log [1024];
  bit prev_we;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_we <= (bus.ram_we === 1'b1);
    if (rst === 1'b0) begin
      if (bus.err) err_cnt <= err_cnt + 1;
      if (bus.ram_we) we_cnt <= we_cnt + 1;
      if (bus.ram_we && prev_we) we_long_cnt <= we_long_cnt + 1;
      if (bus.hw_gnt) gnt_cnt <= gnt_cnt + 1;
      if (bus.ram_en) begin
        en_cnt <= en_cnt + 1;
        if (32'(bus.ram_addr) >= DEPTH) bad_en_cnt <= bad_en_cnt + 1;
        order_log[order_n % 1024] <= bus.hw_gnt;
        order_n <= order_n + 1;
        if (!bus.hw_gnt) spi_acc_cyc <= cyc;
      end
      if (bus.spi_rvalid) begin
        spi_rv_cnt <= spi_rv_cnt + 1;
        last_spi_rdata <= bus.spi_rdata;
        spi_rv_cyc <= cyc;
      end
      if (bus.hw_rvalid) begin
        hw_rv_cnt <= hw_rv_cnt + 1;
        last_hw_rdata <= bus.hw_rdata;
      end
    end
  end

  int n_tests, n_fail;
  logic [7:0] ref_mem [32];
  bit prio_spi;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference CSR access: out-of-range reads return 0, out-of-range writes vanish
  function automatic logic [7:0] model_acc(input bit we, input logic [5:0] a, input logic [7:0] d);
    if (32'(a) >= DEPTH) return 8'h00;
    if (we) begin
      ref_mem[a[4:0]] = d;
      return 8'h00;
    end
    return ref_mem[a[4:0]];
  endfunction

  task automatic spi_send(input logic [7:0] b, input string tag);
    int n;
    n = 0;
    tick();
    bus.spi_valid = 1'b1;
    bus.spi_data  = b;
    while (!bus.spi_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk);
    #1;
    bus.spi_valid = 1'b0;
  endtask

  // One arbitration round: optional SPI access and optional hw access pending together
  task automatic do_round(input bit use_spi, input bit s_we, input logic [5:0] s_a, input logic [7:0] s_d,
                          input bit use_hw, input bit h_we, input logic [5:0] h_a, input logic [7:0] h_d,
                          input string tag);
    bit spi_first, s_done, h_done;
    logic [7:0] s_exp, h_exp;
    int e0, sv0, hv0, we0, en0, g0, o0, exp_err, exp_we, exp_en, n;
    s_exp = 8'h00;
    h_exp = 8'h00;
    spi_first = 1'b1;
`ifdef CSR_ARB_ROUND_ROBIN_EN
    if (use_spi && use_hw) spi_first = prio_spi;
`endif
    if (use_spi && spi_first)  s_exp = model_acc(s_we, s_a, s_d);
    if (use_hw)                h_exp = model_acc(h_we, h_a, h_d);
    if (use_spi && !spi_first) s_exp = model_acc(s_we, s_a, s_d);
    if (use_spi && use_hw) prio_spi = spi_first;
    else if (use_spi)      prio_spi = 1'b0;
    else if (use_hw)       prio_spi = 1'b1;
    exp_err = int'(use_spi && 32'(s_a) >= DEPTH) + int'(use_hw && 32'(h_a) >= DEPTH);
    exp_en  = int'(use_spi && 32'(s_a) < DEPTH) + int'(use_hw && 32'(h_a) < DEPTH);
    exp_we  = int'(use_spi && s_we && 32'(s_a) < DEPTH) + int'(use_hw && h_we && 32'(h_a) < DEPTH);
    e0 = err_cnt; sv0 = spi_rv_cnt; hv0 = hw_rv_cnt; we0 = we_cnt; en0 = en_cnt; g0 = gnt_cnt; o0 = order_n;

    if (use_spi) begin
      spi_send(s_we ? {2'b10, s_a} : {2'b01, s_a}, tag);
      if (s_we) spi_send(s_d, tag);
    end else begin
      tick();
    end
    if (use_hw) begin
      bus.hw_req = 1'b1; bus.hw_we = h_we; bus.hw_addr = h_a; bus.hw_wdata = h_d;
    end

    n = 0; s_done = !use_spi; h_done = !use_hw;
    while (!(s_done && h_done) && n < 60) begin
      tick();
      if (n == 0 && use_spi) check({tag, "_ready_in_pend"}, 32'(bus.spi_ready), 0);
      if (bus.hw_gnt) begin
        bus.hw_req = 1'b0;
        if (h_we) h_done = 1'b1;
      end
      if (use_hw && hw_rv_cnt != hv0) h_done = 1'b1;
      if (use_spi) s_done = s_we ? bus.spi_ready : (spi_rv_cnt != sv0);
      n++;
    end
    if (n >= 60) begin
      check({tag, "_timeout"}, 0, 1);
      bus.hw_req = 1'b0;
    end
    tick();
    tick();

    if (use_spi && !s_we) begin
      check({tag, "_spi_rvalid_cnt"}, spi_rv_cnt - sv0, 1);
      check({tag, "_spi_rdata"}, 32'(last_spi_rdata), 32'(s_exp));
    end
    if (use_hw) check({tag, "_hw_gnt_cnt"}, gnt_cnt - g0, 1);
    if (use_hw && !h_we) begin
      check({tag, "_hw_rvalid_cnt"}, hw_rv_cnt - hv0, 1);
      check({tag, "_hw_rdata"}, 32'(last_hw_rdata), 32'(h_exp));
    end
    check({tag, "_err_cnt"}, err_cnt - e0, exp_err);
    check({tag, "_ram_en_cnt"}, en_cnt - en0, exp_en);
    check({tag, "_ram_we_cycles"}, we_cnt - we0, exp_we);
    if (use_spi && use_hw && exp_en == 2)
      check({tag, "_first_winner_hw"}, 32'(order_log[o0 % 1024]), 32'(!spi_first));
    if (use_spi && !use_hw && !s_we && 32'(s_a) < DEPTH)
      check({tag, "_rd_latency"}, spi_rv_cyc - spi_acc_cyc, 2);
  endtask

  task automatic spi_cmd_only(input logic [7:0] b, input int exp_err, input string tag);
    int e0, en0;
    e0 = err_cnt; en0 = en_cnt;
    spi_send(b, tag);
    repeat (3) tick();
    check({tag, "_err_cnt"}, err_cnt - e0, exp_err);
    check({tag, "_ram_en_cnt"}, en_cnt - en0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 32'({bus.spi_rvalid, bus.hw_gnt, bus.hw_rvalid, bus.ram_en, bus.ram_we, bus.err}), 0);
    check({tag, "_data"}, {bus.spi_rdata, bus.hw_rdata, 2'b00, bus.ram_addr, bus.ram_wdata}, 0);
    check({tag, "_spi_ready"}, 32'(bus.spi_ready), 0);
  endtask

  function automatic logic [5:0] rand_addr();
    return ($urandom_range(0, 99) < 85) ? 6'($urandom_range(0, 31)) : 6'($urandom_range(32, 63));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, hv0, kind;
    rst = 1'b1; ram_load = 1'b1; prio_spi = 1'b1;
    bus.spi_valid = 1'b0; bus.spi_data = '0;
    bus.hw_req = 1'b0; bus.hw_we = 1'b0; bus.hw_addr = '0; bus.hw_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      init_val[i] = 8'($urandom);
      if (i < 32) ref_mem[i] = init_val[i];
    end
    repeat (3) tick();
    check_reset_outputs("reset");
    ram_load = 1'b0;
    rst = 1'b0;
    tick();
    check("ready_after_reset", 32'(bus.spi_ready), 1);

    do_round(1, 1, 6'd5, 8'h5A, 0, 0, 6'd0, 8'h00, "wr5");
    check("ram5_contents", 32'(mem[5]), 32'h5A);
    do_round(1, 0, 6'd5, 8'h00, 0, 0, 6'd0, 8'h00, "rd5");

    do_round(1, 1, 6'd3, 8'hA5, 1, 0, 6'd3, 8'h00, "contend1");
    do_round(0, 0, 6'd0, 8'h00, 1, 1, 6'd10, 8'h3C, "hw_wr10");
    do_round(1, 1, 6'd3, 8'hC3, 1, 0, 6'd3, 8'h00, "contend2");

    do_round(1, 0, 6'd63, 8'h00, 0, 0, 6'd0, 8'h00, "rd63_oob");
    spi_cmd_only(8'hC0, 1, "illegal_op");
    spi_cmd_only(8'h15, 0, "nop");
    do_round(1, 0, 6'd10, 8'h00, 0, 0, 6'd0, 8'h00, "rd10_after_ill");

    // Reset during the RD cycle of a hardware read, with the SPI side mid-write
    spi_send(8'h8A, "rst_cmd");
    hv0 = hw_rv_cnt;
    bus.hw_req = 1'b1; bus.hw_we = 1'b0; bus.hw_addr = 6'd7;
    n = 0;
    while (!bus.hw_gnt && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("rst_hw_gnt_timeout", 0, 1);
    bus.hw_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("reset_in_rd");
    rst = 1'b0;
    tick();
    check("ready_after_rst_in_rd", 32'(bus.spi_ready), 1);
    repeat (3) tick();
    check("hw_rvalid_suppressed", hw_rv_cnt - hv0, 0);
    prio_spi = 1'b1;
    do_round(1, 0, 6'd5, 8'h00, 0, 0, 6'd0, 8'h00, "post_rst_rd5");

    for (int r = 0; r < 60; r++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: do_round(1, 1'($urandom), rand_addr(), 8'($urandom), 0, 0, 6'd0, 8'h00, "rnd_spi");
        1: do_round(0, 0, 6'd0, 8'h00, 1, 1'($urandom), rand_addr(), 8'($urandom), "rnd_hw");
        3: spi_cmd_only(8'hC0 | 8'($urandom_range(0, 63)), 1, "rnd_ill");
        4: spi_cmd_only(8'($urandom_range(0, 63)), 0, "rnd_nop");
        default: do_round(1, 1'($urandom), rand_addr(), 8'($urandom),
                          1, 1'($urandom), rand_addr(), 8'($urandom), "rnd_both");
      endcase
    end

    check("oob_ram_enable", bad_en_cnt, 0);
    check("ram_we_multi_cycle", we_long_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
